// File: rtl/rstack_pkg.sv
// Shared definitions for the return-stack controller, the stack itself and
// the decoder: stack operation encodings, controller FSM states and the
// default geometry of the 64-entry return stack.
package rstack_pkg;

  localparam int DEPTH_DEF = 64;  // stack entries
  localparam int DW_DEF    = 16;  // entry width (return address)
  localparam int CW_DEF    = 7;   // occupancy counter width, 2^CW > DEPTH

  // Operation encoding on stackOP and on the requester op inputs.
  // Codes 0 and 2 are both treated as "no operation" by the controller.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNWIND = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

endpackage

// File: rtl/rstack_arb.sv
// Fixed-priority two-requester arbiter for the return stack.
// The interrupt unit always beats the core decoder; the winner's op and data
// are forwarded to the controller. Purely combinational.
//
// Ports:
//   en_i                 arbitration allowed this cycle
//   irq_req_i/op_i/data_i   interrupt-unit request (higher priority)
//   core_req_i/op_i/data_i  core-decoder request (lower priority)
//   grant_irq_o          interrupt request wins
//   grant_core_o         core request wins
//   op_o, data_o         op and data of the winner (zero when no grant)
module rstack_arb #(
  parameter int DW = 16
) (
  input  logic          en_i,
  input  logic          irq_req_i,
  input  logic [1:0]    irq_op_i,
  input  logic [DW-1:0] irq_data_i,
  input  logic          core_req_i,
  input  logic [1:0]    core_op_i,
  input  logic [DW-1:0] core_data_i,
  output logic          grant_irq_o,
  output logic          grant_core_o,
  output logic [1:0]    op_o,
  output logic [DW-1:0] data_o
);

  // NOTE: every output gets a default before any branch so no path leaves a
  // value unassigned; that is what keeps a combinational block latch-free.
  always_comb begin
    grant_irq_o  = 1'b0;
    grant_core_o = 1'b0;
    op_o         = '0;
    data_o       = '0;
    if (en_i && irq_req_i) begin
      grant_irq_o = 1'b1;
      op_o        = irq_op_i;
      data_o      = irq_data_i;
    end else if (en_i && core_req_i) begin
      grant_core_o = 1'b1;
      op_o         = core_op_i;
      data_o       = core_data_i;
    end
  end

endmodule

// File: rtl/rstack_ctrl.sv
// Return-stack controller: sole driver of the stack's stackOP, w and reset.
// Shares the stack between the core decoder and the interrupt unit, tracks
// occupancy, blocks push-when-full / pop-when-empty with sticky error flags,
// and sequences multi-cycle unwind and single-cycle clear operations.
// All outputs are registered; the stack samples them on the following negedge.
//
// Ports:
//   CLK, reset            clock, asynchronous active-high reset
//   core_req/op/data      core request (1 = push, 3 = pop, other = no-op)
//   core_ack              one-cycle pulse when the core request is serviced
//   irq_req/op/data       interrupt-unit request, same encoding, wins over core
//   irq_ack               one-cycle pulse when the irq request is serviced
//   unwind_req, unwind_cnt  pop min(unwind_cnt, depth) entries, one per cycle
//   clear_req             empty the stack (one-cycle stack reset)
//   err_clr               clear sticky error flags (a same-cycle set wins)
//   stack_op, stack_w, stack_rst  stack control outputs
//   depth, full, empty    occupancy status
//   busy                  unwind or clear in progress
//   ovf_err, unf_err      sticky push-while-full / pop-while-empty flags
module rstack_ctrl
  import rstack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          core_req,
  input  logic [1:0]    core_op,
  input  logic [DW-1:0] core_data,
  output logic          core_ack,
  input  logic          irq_req,
  input  logic [1:0]    irq_op,
  input  logic [DW-1:0] irq_data,
  output logic          irq_ack,
  input  logic          unwind_req,
  input  logic [CW-1:0] unwind_cnt,
  input  logic          clear_req,
  input  logic          err_clr,
  output logic [1:0]    stack_op,
  output logic [DW-1:0] stack_w,
  output logic          stack_rst,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic [CW-1:0] rem_q, rem_d;      // unwind pops still to issue after this one
  op_e           op_q, op_d;
  logic [DW-1:0] w_q, w_d;
  logic          srst_q, srst_d;
  logic          core_ack_q, core_ack_d;
  logic          irq_ack_q, irq_ack_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full_q, empty_q, busy_q;

  logic          unwinding;
  logic          arb_en;
  logic          grant_irq, grant_core;
  logic [1:0]    arb_op;
  logic [DW-1:0] arb_data;
  logic [CW-1:0] unwind_n;

  // An unwind keeps popping while pops remain. Otherwise the controller is
  // free again; only a truly idle FSM may accept clear/unwind, so on the
  // cycle that ends a busy phase the requesters are arbitrated directly.
  assign unwinding = (state_q == ST_UNWIND) && (rem_q != '0);
  assign arb_en    = !unwinding &&
                     !((state_q == ST_IDLE) && (clear_req || unwind_req));

  // Requests larger than the occupancy are silently truncated.
  assign unwind_n  = (unwind_cnt < depth_q) ? unwind_cnt : depth_q;

  rstack_arb #(.DW(DW)) u_arb (
    .en_i        (arb_en),
    .irq_req_i   (irq_req),
    .irq_op_i    (irq_op),
    .irq_data_i  (irq_data),
    .core_req_i  (core_req),
    .core_op_i   (core_op),
    .core_data_i (core_data),
    .grant_irq_o (grant_irq),
    .grant_core_o(grant_core),
    .op_o        (arb_op),
    .data_o      (arb_data)
  );

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    rem_d      = rem_q;
    op_d       = OP_IDLE;
    w_d        = w_q;        // stack_w holds while no op is driven
    srst_d     = 1'b0;
    core_ack_d = 1'b0;
    irq_ack_d  = 1'b0;
    // Clear first, then set below: a same-cycle error event wins.
    ovf_d      = ovf_q & ~err_clr;
    unf_d      = unf_q & ~err_clr;

    if (unwinding) begin
      op_d    = OP_POP;
      depth_d = depth_q - ONE_C;
      rem_d   = rem_q - ONE_C;
    end else begin
      state_d = ST_IDLE;
      if ((state_q == ST_IDLE) && clear_req) begin
        state_d = ST_CLEAR;
        srst_d  = 1'b1;
        depth_d = '0;
        rem_d   = '0;
      end else if ((state_q == ST_IDLE) && unwind_req) begin
        // The first pop is issued immediately; rem counts the rest.
        if (unwind_n != '0) begin
          state_d = ST_UNWIND;
          op_d    = OP_POP;
          depth_d = depth_q - ONE_C;
          rem_d   = unwind_n - ONE_C;
        end
      end else if (grant_irq || grant_core) begin
        irq_ack_d  = grant_irq;
        core_ack_d = grant_core;
        if (arb_op == OP_PUSH) begin
          if (depth_q == DEPTH_C) begin
            ovf_d = 1'b1;
          end else begin
            op_d    = OP_PUSH;
            w_d     = arb_data;
            depth_d = depth_q + ONE_C;
          end
        end else if (arb_op == OP_POP) begin
          if (depth_q == '0) begin
            unf_d = 1'b1;
          end else begin
            op_d    = OP_POP;
            w_d     = arb_data;
            depth_d = depth_q - ONE_C;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      depth_q    <= '0;
      rem_q      <= '0;
      op_q       <= OP_IDLE;
      w_q        <= '0;
      srst_q     <= 1'b1;   // held through reset and the first cycle after
      core_ack_q <= 1'b0;
      irq_ack_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      w_q        <= w_d;
      srst_q     <= srst_d;
      core_ack_q <= core_ack_d;
      irq_ack_q  <= irq_ack_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      full_q     <= (depth_d == DEPTH_C);
      empty_q    <= (depth_d == '0);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign stack_op  = op_q;
  assign stack_w   = w_q;
  assign stack_rst = srst_q;
  assign core_ack  = core_ack_q;
  assign irq_ack   = irq_ack_q;
  assign depth     = depth_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign busy      = busy_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Self-checking bench for rstack_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the stack and its sharing rules.
module tb_rstack_ctrl;

  localparam int DEPTH = 64;
  localparam int DW    = 16;
  localparam int CW    = 7;

  logic          CLK = 1'b0;
  logic          reset;
  logic          core_req, irq_req, unwind_req, clear_req, err_clr;
  logic [1:0]    core_op, irq_op;
  logic [DW-1:0] core_data, irq_data;
  logic [CW-1:0] unwind_cnt;
  logic          core_ack, irq_ack, stack_rst, full, empty, busy, ovf_err, unf_err;
  logic [1:0]    stack_op;
  logic [DW-1:0] stack_w;
  logic [CW-1:0] depth;

  int checks   = 0;
  int failures = 0;

  rstack_ctrl #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .core_req  (core_req),
    .core_op   (core_op),
    .core_data (core_data),
    .core_ack  (core_ack),
    .irq_req   (irq_req),
    .irq_op    (irq_op),
    .irq_data  (irq_data),
    .irq_ack   (irq_ack),
    .unwind_req(unwind_req),
    .unwind_cnt(unwind_cnt),
    .clear_req (clear_req),
    .err_clr   (err_clr),
    .stack_op  (stack_op),
    .stack_w   (stack_w),
    .stack_rst (stack_rst),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_stack[$];     // stack contents, back = top
  int          m_pend;         // unwind pops still owed
  bit          e_busy, e_rst, e_core_ack, e_irq_ack, e_ovf, e_unf, m_was_busy;
  logic [1:0]  e_op;
  logic [15:0] e_w;
  int          m_n;

  task automatic model_serve(input logic [1:0] op, input logic [15:0] data);
    if (op == 2'd1) begin
      if (m_stack.size() == DEPTH) e_ovf = 1'b1;
      else begin m_stack.push_back(int'(data)); e_op = 2'd1; e_w = data; end
    end else if (op == 2'd3) begin
      if (m_stack.size() == 0) e_unf = 1'b1;
      else begin void'(m_stack.pop_back()); e_op = 2'd3; e_w = data; end
    end
  endtask

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_stack.delete();
      m_pend = 0; e_busy = 0; e_rst = 1; e_core_ack = 0; e_irq_ack = 0;
      e_ovf = 0; e_unf = 0; e_op = 2'd0; e_w = '0;
    end else begin
      m_was_busy = e_busy;
      e_busy = 0; e_rst = 0; e_core_ack = 0; e_irq_ack = 0; e_op = 2'd0;
      if (err_clr) begin e_ovf = 0; e_unf = 0; end
      if (m_pend > 0) begin
        void'(m_stack.pop_back()); m_pend--; e_op = 2'd3; e_busy = 1;
      end else if (!m_was_busy && clear_req) begin
        m_stack.delete(); e_rst = 1; e_busy = 1;
      end else if (!m_was_busy && unwind_req) begin
        m_n = (int'(unwind_cnt) < m_stack.size()) ? int'(unwind_cnt) : m_stack.size();
        if (m_n > 0) begin
          void'(m_stack.pop_back()); m_pend = m_n - 1; e_op = 2'd3; e_busy = 1;
        end
      end else if (irq_req) begin
        e_irq_ack = 1; model_serve(irq_op, irq_data);
      end else if (core_req) begin
        e_core_ack = 1; model_serve(core_op, core_data);
      end
    end
  end

  // Outputs change only at posedge / reset; compare on every negedge.
  always @(negedge CLK) begin
    check("stack_op",  32'(stack_op),  32'(e_op));
    check("stack_w",   32'(stack_w),   32'(e_w));
    check("core_ack",  32'(core_ack),  32'(e_core_ack));
    check("irq_ack",   32'(irq_ack),   32'(e_irq_ack));
    check("depth",     32'(depth),     32'(m_stack.size()));
    check("full",      32'(full),      32'(m_stack.size() == DEPTH));
    check("empty",     32'(empty),     32'(m_stack.size() == 0));
    check("busy",      32'(busy),      32'(e_busy));
    check("ovf_err",   32'(ovf_err),   32'(e_ovf));
    check("unf_err",   32'(unf_err),   32'(e_unf));
    check("stack_rst", 32'(stack_rst), 32'(e_rst));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [1:0] pick_op(input bit push_bias);
    int r;
    r = $urandom_range(0, 99);
    if (r < 5)  return 2'd0;
    if (r < 10) return 2'd2;
    if (r < 75) return push_bias ? 2'd1 : 2'd3;
    return push_bias ? 2'd3 : 2'd1;
  endfunction

  initial begin
    reset = 1'b1;
    core_req = 0; core_op = 0; core_data = '0;
    irq_req = 0; irq_op = 0; irq_data = '0;
    unwind_req = 0; unwind_cnt = '0; clear_req = 0; err_clr = 0;
    repeat (3) tick();
    check("rst_depth", 32'(depth), 0);
    check("rst_stack_rst", 32'(stack_rst), 1);

    // Release reset together with the first core push.
    reset = 1'b0;
    core_req = 1; core_op = 2'd1; core_data = 16'h1234;
    #1 check("rel_stack_rst", 32'(stack_rst), 1);
    tick();
    check("p1_ack", 32'(core_ack), 1); check("p1_op", 32'(stack_op), 1);
    check("p1_depth", 32'(depth), 1);  check("p1_w", 32'(stack_w), 16'h1234);
    check("p1_stack_rst", 32'(stack_rst), 0);
    core_data = 16'h5678;
    tick();
    check("p2_ack", 32'(core_ack), 1); check("p2_op", 32'(stack_op), 1);
    check("p2_depth", 32'(depth), 2);  check("p2_w", 32'(stack_w), 16'h5678);
    core_op = 2'd3;
    tick();
    check("pop_ack", 32'(core_ack), 1); check("pop_op", 32'(stack_op), 3);
    check("pop_depth", 32'(depth), 1);
    core_req = 0;

    // Simultaneous requests: irq first, core next cycle.
    core_req = 1; core_op = 2'd1; core_data = 16'hAAAA;
    irq_req = 1; irq_op = 2'd1; irq_data = 16'hBBBB;
    tick();
    check("arb_irq_ack", 32'(irq_ack), 1); check("arb_core_wait", 32'(core_ack), 0);
    check("arb_w_irq", 32'(stack_w), 16'hBBBB); check("arb_depth1", 32'(depth), 2);
    irq_req = 0;
    tick();
    check("arb_core_ack", 32'(core_ack), 1); check("arb_w_core", 32'(stack_w), 16'hAAAA);
    check("arb_depth2", 32'(depth), 3);

    // Fill to 64 and overflow.
    repeat (61) tick();
    check("fill_depth", 32'(depth), 64); check("fill_full", 32'(full), 1);
    tick();
    check("ovf_ack", 32'(core_ack), 1); check("ovf_op", 32'(stack_op), 0);
    check("ovf_flag", 32'(ovf_err), 1); check("ovf_depth", 32'(depth), 64);
    core_req = 0; err_clr = 1;
    tick();
    check("ovf_cleared", 32'(ovf_err), 0);
    err_clr = 0;

    // Pop down to 5, then unwind 9 with a core push waiting.
    core_req = 1; core_op = 2'd3;
    repeat (59) tick();
    check("pre_unw_depth", 32'(depth), 5);
    core_op = 2'd1; core_data = 16'h7777;
    unwind_req = 1; unwind_cnt = 7'd9;
    tick();
    check("unw_busy", 32'(busy), 1); check("unw_op", 32'(stack_op), 3);
    check("unw_depth", 32'(depth), 4); check("unw_no_ack", 32'(core_ack), 0);
    unwind_req = 0;
    repeat (4) tick();
    check("unw_last_busy", 32'(busy), 1); check("unw_last_depth", 32'(depth), 0);
    tick();
    check("unw_done_busy", 32'(busy), 0); check("unw_core_ack", 32'(core_ack), 1);
    check("unw_core_depth", 32'(depth), 1); check("unw_no_unf", 32'(unf_err), 0);
    check("unw_no_ovf", 32'(ovf_err), 0);

    // Pop to empty, underflow, refill 3, clear.
    core_op = 2'd3;
    tick();
    check("pe_depth", 32'(depth), 0);
    tick();
    check("unf_ack", 32'(core_ack), 1); check("unf_op", 32'(stack_op), 0);
    check("unf_flag", 32'(unf_err), 1);
    core_op = 2'd1;
    repeat (3) tick();
    check("clr_pre_depth", 32'(depth), 3);
    core_req = 0; clear_req = 1;
    tick();
    check("clr_rst", 32'(stack_rst), 1); check("clr_depth", 32'(depth), 0);
    check("clr_busy", 32'(busy), 1); check("clr_op", 32'(stack_op), 0);
    clear_req = 0; err_clr = 1;
    tick();
    check("clr_rst_done", 32'(stack_rst), 0); check("clr_busy_done", 32'(busy), 0);
    err_clr = 0;

    // Randomized traffic.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit bias;
      bias = ((cyc / 250) % 2) == 0;
      if (!core_req || e_core_ack) begin
        core_req = ($urandom_range(0, 99) < 60);
        core_op = pick_op(bias); core_data = 16'($urandom);
      end
      if (!irq_req || e_irq_ack) begin
        irq_req = ($urandom_range(0, 99) < 30);
        irq_op = pick_op(bias); irq_data = 16'($urandom);
      end
      unwind_req = ($urandom_range(0, 39) == 0);
      unwind_cnt = 7'($urandom_range(0, 20));
      clear_req  = ($urandom_range(0, 149) == 0);
      err_clr    = ($urandom_range(0, 24) == 0);
      tick();
    end

    // Reset in the middle of an unwind.
    core_req = 0; irq_req = 0; unwind_req = 0; clear_req = 0; err_clr = 0;
    repeat (3) tick();
    core_req = 1; core_op = 2'd1; core_data = 16'h4242;
    repeat (10) tick();
    core_req = 0; unwind_req = 1; unwind_cnt = 7'd20;
    tick();
    unwind_req = 0;
    tick();
    check("mid_unw_busy", 32'(busy), 1);
    @(posedge CLK);
    #2 reset = 1'b1;
    #1;
    check("mr_depth", 32'(depth), 0); check("mr_op", 32'(stack_op), 0);
    check("mr_busy", 32'(busy), 0);   check("mr_ovf", 32'(ovf_err), 0);
    check("mr_unf", 32'(unf_err), 0); check("mr_stack_rst", 32'(stack_rst), 1);
    tick();
    tick();
    reset = 1'b0;
    #1 check("mr_rel_stack_rst", 32'(stack_rst), 1);
    tick();
    check("mr_after_stack_rst", 32'(stack_rst), 0);
    check("mr_after_depth", 32'(depth), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
